// File: rtl/vdc_pkg.sv
// rtl/vdc_pkg.sv - shared types and address-step helper for the VDC VRAM master
package vdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RD_CAP  = 2'd3
  } cpu_state_t;

  localparam logic [1:0] INC_1   = 2'b00;
  localparam logic [1:0] INC_32  = 2'b01;
  localparam logic [1:0] INC_64  = 2'b10;
  localparam logic [1:0] INC_128 = 2'b11;

  function automatic logic [15:0] step_of(input logic [1:0] sel);
    case (sel)
      INC_1:   step_of = 16'd1;
      INC_32:  step_of = 16'd32;
      INC_64:  step_of = 16'd64;
      default: step_of = 16'd128;
    endcase
  endfunction

endpackage

// File: rtl/vdc_addr_step.sv
// rtl/vdc_addr_step.sv - 16-bit address register with load and wrapping increment
// addr_nxt is the value the register takes at this edge, so an access granted now sees a same-edge load/step.
module vdc_addr_step (
  input  logic        clock,
  input  logic        reset_N,
  input  logic        ld,
  input  logic [15:0] ld_val,
  input  logic        inc,
  input  logic [15:0] step,
  output logic [15:0] addr_nxt
);

  logic [15:0] addr;

  always_comb begin
    addr_nxt = addr;
    if (ld)
      addr_nxt = ld_val;
    else if (inc)
      addr_nxt = addr + step;
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N)
      addr <= 16'h0000;
    else
      addr <= addr_nxt;
  end

endmodule

// File: rtl/vdc_vram_master.sv
// rtl/vdc_vram_master.sv - HuC6270 VRAM port arbiter between display fetch and CPU MAWR/MARR/VWR/VRR
// Build option: VDC_READ_PREFETCH_EN makes marr_ld prefetch into vrr_data.
module vdc_vram_master
  import vdc_pkg::*;
(
  input  logic        clock,
  input  logic        reset_N,
  input  logic [15:0] cpu_data,
  input  logic        mawr_ld,
  input  logic        marr_ld,
  input  logic        vwr_wr,
  input  logic        vrr_rd,
  input  logic [1:0]  inc_sel,
  output logic [15:0] vrr_data,
  output logic        cpu_busy,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic        fetch_valid,
  output logic [15:0] fetch_data,
  output logic [15:0] MA,
  output logic        re,
  output logic        we,
  output logic [15:0] MD_in,
  input  logic [15:0] MD_out
);

  cpu_state_t  state, state_n;
  logic [15:0] mawr_nxt, marr_nxt, wr_buf, step;
  logic        rd_tag, pf_defer, pf_defer_n, pf_now, busy_n;
  logic        mawr_g, marr_g, vwr_g, vrr_g, wr_acc, rd_acc;
  logic        pend_wr, pend_rd, grant_wr, grant_rd, cap_cpu, cap_fetch;

  assign step = step_of(inc_sel);

  // Strobes are one-hot; on collision the lower-priority ones are dropped.
  assign mawr_g = mawr_ld;
  assign marr_g = marr_ld & ~mawr_ld;
  assign vwr_g  = vwr_wr & ~mawr_ld & ~marr_ld;
  assign vrr_g  = vrr_rd & ~mawr_ld & ~marr_ld & ~vwr_wr;
  assign wr_acc = vwr_g & ~cpu_busy;
  assign rd_acc = vrr_g & ~cpu_busy;

  // rd_tag marks the read on the bus this cycle as the CPU's; MD_out is captured at the edge ending it.
  assign cap_cpu   = re & rd_tag;
  assign cap_fetch = re & ~rd_tag;

  vdc_addr_step u_mawr (
    .clock    (clock),
    .reset_N  (reset_N),
    .ld       (mawr_g),
    .ld_val   (cpu_data),
    .inc      (we),
    .step     (step),
    .addr_nxt (mawr_nxt)
  );

  vdc_addr_step u_marr (
    .clock    (clock),
    .reset_N  (reset_N),
    .ld       (marr_g),
    .ld_val   (cpu_data),
    .inc      (cap_cpu),
    .step     (step),
    .addr_nxt (marr_nxt)
  );

`ifdef VDC_READ_PREFETCH_EN
  // A MARR load that lands mid-access is remembered and prefetched once the FSM is idle again.
  assign pf_now = (marr_g & (state == IDLE)) | (pf_defer & (state == IDLE));
  always_comb begin
    pf_defer_n = pf_defer;
    if (state == IDLE)
      pf_defer_n = 1'b0;
    if (marr_g && (state == WR_WAIT || state == RD_CAP))
      pf_defer_n = 1'b1;
  end
`else
  assign pf_now     = 1'b0;
  assign pf_defer_n = 1'b0;
`endif

  always_comb begin
    pend_wr  = (state == WR_WAIT) | wr_acc;
    pend_rd  = (state == RD_WAIT) | rd_acc | pf_now;
    grant_wr = ~fetch_req & pend_wr;
    grant_rd = ~fetch_req & ~pend_wr & pend_rd;
    state_n  = IDLE;
    if (pend_wr)
      state_n = grant_wr ? IDLE : WR_WAIT;
    else if (pend_rd)
      state_n = grant_rd ? RD_CAP : RD_WAIT;
    busy_n = (state_n != IDLE) | pf_defer_n;
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state       <= IDLE;
      pf_defer    <= 1'b0;
      cpu_busy    <= 1'b0;
      wr_buf      <= 16'h0000;
      rd_tag      <= 1'b0;
      re          <= 1'b0;
      we          <= 1'b0;
      MA          <= 16'h0000;
      MD_in       <= 16'h0000;
      fetch_ack   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= 16'h0000;
      vrr_data    <= 16'h0000;
    end else begin
      state     <= state_n;
      pf_defer  <= pf_defer_n;
      cpu_busy  <= busy_n;
      re        <= fetch_req | grant_rd;
      we        <= grant_wr;
      fetch_ack <= fetch_req;
      rd_tag    <= grant_rd;
      if (wr_acc)
        wr_buf <= cpu_data;
      if (fetch_req) begin
        MA <= fetch_addr;
      end else if (grant_wr) begin
        MA    <= mawr_nxt;
        MD_in <= wr_acc ? cpu_data : wr_buf;
      end else if (grant_rd) begin
        MA <= marr_nxt;
      end
      fetch_valid <= cap_fetch;
      if (cap_fetch)
        fetch_data <= MD_out;
      if (cap_cpu)
        vrr_data <= MD_out;
    end
  end

endmodule
